// File: rtl/vx_mem_tag_remap.sv
// vx_mem_tag_remap
//   Swaps the wide memory tag coming out of the cache bypass stage for a
//   compact slot index, and restores the wide tag when the matching response
//   comes back. At most NUM_SLOTS reads are outstanding per port.
//
// Ports
//   clk, reset              clock, asynchronous active-low reset
//   req_in_*                request from the bypass stage (wide tag)
//   req_out_*               request toward memory (tag = slot index, 0 on writes)
//   rsp_in_*                response from memory (tag = slot index)
//   rsp_out_*               response toward the bypass stage (wide tag restored)
//   pending_count           number of allocated slots
//   full                    every slot is allocated; reads stall, writes still pass
module vx_mem_tag_remap #(
    parameter  int LINE_SIZE    = 64,
    parameter  int ADDR_WIDTH   = 26,
    parameter  int FLAGS_WIDTH  = 4,
    parameter  int TAG_IN_WIDTH = 16,
    parameter  int NUM_SLOTS    = 8,
    localparam int SLOT_BITS    = $clog2(NUM_SLOTS),
    localparam int DATA_WIDTH   = LINE_SIZE * 8
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    req_in_valid,
    output logic                    req_in_ready,
    input  logic                    req_in_rw,
    input  logic [ADDR_WIDTH-1:0]   req_in_addr,
    input  logic [DATA_WIDTH-1:0]   req_in_data,
    input  logic [LINE_SIZE-1:0]    req_in_byteen,
    input  logic [FLAGS_WIDTH-1:0]  req_in_flags,
    input  logic [TAG_IN_WIDTH-1:0] req_in_tag,

    output logic                    req_out_valid,
    input  logic                    req_out_ready,
    output logic                    req_out_rw,
    output logic [ADDR_WIDTH-1:0]   req_out_addr,
    output logic [DATA_WIDTH-1:0]   req_out_data,
    output logic [LINE_SIZE-1:0]    req_out_byteen,
    output logic [FLAGS_WIDTH-1:0]  req_out_flags,
    output logic [SLOT_BITS-1:0]    req_out_tag,

    input  logic                    rsp_in_valid,
    output logic                    rsp_in_ready,
    input  logic [DATA_WIDTH-1:0]   rsp_in_data,
    input  logic [SLOT_BITS-1:0]    rsp_in_tag,

    output logic                    rsp_out_valid,
    input  logic                    rsp_out_ready,
    output logic [DATA_WIDTH-1:0]   rsp_out_data,
    output logic [TAG_IN_WIDTH-1:0] rsp_out_tag,

    output logic [SLOT_BITS:0]      pending_count,
    output logic                    full
);

    logic [NUM_SLOTS-1:0]    slot_valid;
    logic [TAG_IN_WIDTH-1:0] slot_tag [NUM_SLOTS];
    logic [SLOT_BITS-1:0]    alloc_slot;
    logic                    pass_ok;
    logic                    alloc_fire;
    logic                    free_fire;

    // full comes from registered state only, so a slot freed this cycle is
    // not visible to the allocator until the next cycle.
    assign full = (pending_count == (SLOT_BITS+1)'(NUM_SLOTS));

    // Writes never allocate, so they are never blocked by a full table.
    assign pass_ok        = req_in_rw | ~full;
    assign req_out_valid  = req_in_valid & pass_ok;
    assign req_in_ready   = req_out_ready & pass_ok;
    assign req_out_rw     = req_in_rw;
    assign req_out_addr   = req_in_addr;
    assign req_out_data   = req_in_data;
    assign req_out_byteen = req_in_byteen;
    assign req_out_flags  = req_in_flags;
    assign req_out_tag    = req_in_rw ? '0 : alloc_slot;

    assign rsp_out_valid = rsp_in_valid;
    assign rsp_in_ready  = rsp_out_ready;
    assign rsp_out_data  = rsp_in_data;
    assign rsp_out_tag   = slot_tag[rsp_in_tag];

    assign alloc_fire = req_out_valid & req_out_ready & ~req_in_rw;
    assign free_fire  = rsp_in_valid & rsp_out_ready;

    // Lowest-index free slot; scanning downward lets the lowest hit win.
    always_comb begin
        alloc_slot = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_valid[i]) alloc_slot = SLOT_BITS'(i);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_valid <= '0;
        end else begin
            if (free_fire)  slot_valid[rsp_in_tag] <= 1'b0;
            if (alloc_fire) slot_valid[alloc_slot] <= 1'b1;
        end
    end

    // Tag storage needs no reset: an entry is only read while its slot is valid.
    always_ff @(posedge clk) begin
        if (alloc_fire) slot_tag[alloc_slot] <= req_in_tag;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_count <= '0;
        end else begin
            case ({alloc_fire, free_fire})
                2'b10:   pending_count <= pending_count + 1'b1;
                2'b01:   if (pending_count != '0) pending_count <= pending_count - 1'b1;
                default: pending_count <= pending_count;
            endcase
        end
    end

    // Protocol checks: responses must target a live slot, reads never fire when full.
    a_rsp_live: assert property (@(posedge clk) disable iff (!reset)
        free_fire |-> slot_valid[rsp_in_tag]);
    a_no_alloc_full: assert property (@(posedge clk) disable iff (!reset)
        !(alloc_fire && full));

endmodule
